csr_trap_unit: RTL
==================

# csr_trap_unit

Machine-mode CSR file, trap sequencer and machine timer for the single-cycle RV32I core. Consumes the decoder's `csr_op`, `excRequest`, `excCause`, `excRet` and `inst_invalid` outputs and the retiring PC. Produces CSR read data for the `regData = 2'b10` writeback path, the `PC_MTVEC`/`PC_MEPEC` targets and the `exceptionPresent` signal that feeds back into the decoder's PC-source selection.

## Interface

**Clocking and reset (already decided):** one clock; reset is synchronous and active-high.

Parameters:
- `RESET_MTVEC`, default `32'h0000_0100`: reset value of `mtvec`.
- `TIMER_DIV`, default `1`: `clk` cycles per `mtime` tick (≥1).

Ports:
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `retire` in 1: instruction in this cycle is valid and commits at the next edge.
- `pc` in 32: PC of the current instruction.
- `csr_op` in 2: 0 none, 1 write, 2 set, 3 clear.
- `csr_addr` in 12: `instr[31:20]`.
- `csr_wdata` in 32: rs1 value or zero-extended zimm, already selected by `csr_source`.
- `exc_request` in 1: ECALL/EBREAK.
- `exc_cause` in 32: cause supplied with `exc_request`/`inst_invalid`.
- `inst_invalid` in 1: illegal instruction from the decoder.
- `exc_ret` in 1: MRET.
- `tmr_we` in 1: timer write strobe from the data bus.
- `tmr_addr` in 2: 0 `mtime` lo, 1 `mtime` hi, 2 `mtimecmp` lo, 3 `mtimecmp` hi.
- `tmr_wdata` in 32: timer write data.
- `tmr_rdata` out 32: timer read data, combinational on `tmr_addr`; feeds the `mem_from_mtime` path.
- `csr_rdata` out 32: old value of the addressed CSR, combinational.
- `exception_present` out 1: a trap is taken this cycle.
- `trap_vector` out 32: `{mtvec[31:2],2'b00}`.
- `mepc_out` out 32: current `mepc`.

## Operation

**Implemented CSRs:**
- `mstatus` (0x300): only MIE[3] and MPIE[7] are stored; all other bits read 0.
- `mie` (0x304): only MTIE[7] is stored.
- `mip` (0x344): read-only; MTIP[7] = (`mtime` ≥ `mtimecmp`), unsigned 64-bit compare.
- `mtvec` (0x305), `mscratch` (0x340), `mepc` (0x341, bits [1:0] forced 0), `mcause` (0x342).
- `mcycle`/`mcycleh` (0xB00/0xB80): writable.
- `minstret`/`minstreth` (0xB02/0xB82): writable.
- `mhartid` (0xF14): reads 0.
- Writes to read-only addresses are ignored.

**CSR writes:**
- A write occurs when `retire && csr_op != 0` and no trap is taken.
- New value: write = `wdata`; set = `old | wdata`; clear = `old & ~wdata`.
- Set or clear with `csr_wdata == 0` performs no write.
- An unimplemented `csr_addr` with `csr_op != 0` raises an illegal-instruction trap, cause 2.

**Trap conditions**, evaluated only when `retire`, in priority order:
1. Interrupt: MIE & MTIE & MTIP. Cause `32'h8000_0007`.
2. `inst_invalid` or unimplemented CSR. Cause 2.
3. `exc_request`. Cause `exc_cause`.

**On a trap:**
- `exception_present = 1` (combinational).
- At the next edge: `mepc ← pc`, `mcause ← cause`, MPIE ← MIE, MIE ← 0.
- The instruction's CSR write and MRET effect are suppressed.
- `minstret` does not increment.

**MRET** (`exc_ret`, no trap): MIE ← MPIE, MPIE ← 1.

**Counters:**
- `mcycle` increments every cycle out of reset.
- `minstret` increments on each `retire` without a trap.
- A CSR write to either counter takes precedence over its increment in the same cycle.
- Both counters are 64-bit and wrap to 0.

**Timer:**
- `mtime` increments once every `TIMER_DIV` cycles and wraps.
- A `tmr_we` write to `mtime` takes precedence over the tick, and the prescaler restarts at 0.

## Timing

**Reset values** (all registers reset at the `clk` edge while `rst` = 1; `rst` mid-operation discards any pending trap or write):
- `mtvec` = `RESET_MTVEC`; `mtimecmp` = all ones.
- All other registers 0.
- `exception_present` = 0 during reset.

**Latency:**
- `csr_rdata`, `tmr_rdata`, `exception_present`, `trap_vector` and `mepc_out` are combinational, with 0-cycle latency.
- Register updates are visible on the cycle after the edge.
- MTIP reflects a `mtimecmp` write in the following cycle.
- A CSR read-modify-write in one instruction returns the pre-write value.
- The same PC may retire again after MRET; no stall cycles are ever generated.

## Structure

- **Shared package `Common`:**
  - CSR address constants.
  - `csr_op_t` (2-bit enum).
  - Cause constants (`CAUSE_ILLEGAL` = 2, `CAUSE_BREAK` = 3, `CAUSE_ECALL_M` = 11, `CAUSE_MTIMER` = `32'h8000_0007`).
  - Reset constants.
- **Sub-module `machine_timer`:** holds `mtime`, `mtimecmp`, the prescaler, the bus port and the MTIP output.

## Test plan

- **Reset and CSRRW:**
  - Stimulus: after `rst`, read `mtvec`; then CSRRW `mscratch` with `0xDEADBEEF`.
  - Response: the read gives `0x100`; CSRRW returns 0; a subsequent read returns `0xDEADBEEF`.
- **ECALL:**
  - Stimulus: `retire`, `exc_request`, `exc_cause` = 11, `pc` = `0x40`, MIE = 1.
  - Response: `exception_present` = 1; next cycle `mepc` = `0x40`, `mcause` = 11, MIE = 0, MPIE = 1; `minstret` unchanged.
- **MRET:**
  - Stimulus: MRET following the ECALL trap.
  - Response: MIE = 1, MPIE = 1; `mepc_out` = `0x40`.
- **Timer interrupt:**
  - Stimulus: `mtimecmp` = 5, `TIMER_DIV` = 1, MTIE = MIE = 1.
  - Response: MTIP sets when `mtime` = 5; the first retiring instruction traps with `mcause` = `0x80000007` and the `mepc` of that instruction; a simultaneous CSRRW is suppressed.
- **Illegal CSR address and priority:**
  - Stimulus: CSRRS on 0x7C0 with `csr_wdata` = 1; then `exc_request` together with `inst_invalid`.
  - Response: cause 2 in both cases.
- **Counter wrap:**
  - Stimulus: write `mcycle` = `0xFFFFFFFF`, `mcycleh` = `0xFFFFFFFF`.
  - Response: one cycle later `mcycle` = 0, `mcycleh` = 0.

Source files
------------

// File: rtl/csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, operation encoding, trap causes and reset values.
package csr_trap_unit_pkg;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_op_t;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_BREAK   = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] CAUSE_MTIMER  = 32'h8000_0007;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIE_MTIE_BIT     = 7;
    localparam int MIP_MTIP_BIT     = 7;

    localparam logic [31:0] RST_MTVEC    = 32'h0000_0100;
    localparam logic [63:0] RST_MTIMECMP = {64{1'b1}};

    function automatic logic [31:0] csr_apply(input csr_op_t op, input logic [31:0] old_val,
                                              input logic [31:0] wdata);
        case (op)
            CSR_WRITE: return wdata;
            CSR_SET:   return old_val | wdata;
            CSR_CLEAR: return old_val & ~wdata;
            default:   return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_trap_unit_machine_timer.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, mtimecmp and the
// MTIP level derived from their unsigned comparison.
module machine_timer
    import csr_trap_unit_pkg::*;
#(
    parameter int unsigned TIMER_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        mtip_o
);

    localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0] RELOAD = PW'(TIMER_DIV - 1);

    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic [PW-1:0] presc_q, presc_d;

    // Prescaler counts down from TIMER_DIV-1; mtime ticks at terminal count.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (presc_q == '0) begin
            mtime_d = mtime_q + 64'd1;
            presc_d = RELOAD;
        end else begin
            presc_d = presc_q - PW'(1);
        end
        if (we_i) begin
            case (addr_i)
                2'd0: begin
                    mtime_d = {mtime_q[63:32], wdata_i};
                    presc_d = RELOAD;
                end
                2'd1: begin
                    mtime_d = {wdata_i, mtime_q[31:0]};
                    presc_d = RELOAD;
                end
                2'd2: mtimecmp_d = {mtimecmp_q[63:32], wdata_i};
                default: mtimecmp_d = {wdata_i, mtimecmp_q[31:0]};
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q    <= '0;
            mtimecmp_q <= RST_MTIMECMP;
            presc_q    <= RELOAD;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            presc_q    <= presc_d;
        end
    end

    always_comb begin
        case (addr_i)
            2'd0:    rdata_o = mtime_q[31:0];
            2'd1:    rdata_o = mtime_q[63:32];
            2'd2:    rdata_o = mtimecmp_q[31:0];
            default: rdata_o = mtimecmp_q[63:32];
        endcase
    end

    assign mtip_o = (mtime_q >= mtimecmp_q);

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer for the single-cycle RV32I core.
// Traps, MRET and CSR writes all commit at the edge ending the retiring cycle.
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
    parameter int unsigned TIMER_DIV   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        retire_i,
    input  logic [31:0] pc_i,
    input  logic [1:0]  csr_op_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic        exc_request_i,
    input  logic [31:0] exc_cause_i,
    input  logic        inst_invalid_i,
    input  logic        exc_ret_i,
    input  logic        tmr_we_i,
    input  logic [1:0]  tmr_addr_i,
    input  logic [31:0] tmr_wdata_i,
    output logic [31:0] tmr_rdata_o,
    output logic [31:0] csr_rdata_o,
    output logic        exception_present_o,
    output logic [31:0] trap_vector_o,
    output logic [31:0] mepc_out_o
);

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic        mtip;
    csr_op_t     op;
    logic        csr_impl, csr_ro, csr_active, csr_illegal, csr_nop, csr_we;
    logic        irq_pending, trap;
    logic [31:0] trap_cause, csr_new;

    machine_timer #(.TIMER_DIV(TIMER_DIV)) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (tmr_we_i),
        .addr_i  (tmr_addr_i),
        .wdata_i (tmr_wdata_i),
        .rdata_o (tmr_rdata_o),
        .mtip_o  (mtip)
    );

    always_comb begin
        csr_impl    = 1'b1;
        csr_ro      = 1'b0;
        csr_rdata_o = '0;
        case (csr_addr_i)
            CSR_MSTATUS: begin
                csr_rdata_o[MSTATUS_MIE_BIT]  = mstatus_mie_q;
                csr_rdata_o[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
            end
            CSR_MIE:       csr_rdata_o[MIE_MTIE_BIT] = mie_mtie_q;
            CSR_MIP: begin
                csr_rdata_o[MIP_MTIP_BIT] = mtip;
                csr_ro = 1'b1;
            end
            CSR_MTVEC:     csr_rdata_o = mtvec_q;
            CSR_MSCRATCH:  csr_rdata_o = mscratch_q;
            CSR_MEPC:      csr_rdata_o = mepc_q;
            CSR_MCAUSE:    csr_rdata_o = mcause_q;
            CSR_MCYCLE:    csr_rdata_o = mcycle_q[31:0];
            CSR_MCYCLEH:   csr_rdata_o = mcycle_q[63:32];
            CSR_MINSTRET:  csr_rdata_o = minstret_q[31:0];
            CSR_MINSTRETH: csr_rdata_o = minstret_q[63:32];
            CSR_MHARTID:   csr_ro = 1'b1;
            default:       csr_impl = 1'b0;
        endcase
    end

    assign op          = csr_op_t'(csr_op_i);
    assign csr_active  = (op != CSR_NONE);
    assign csr_illegal = csr_active & ~csr_impl;
    assign irq_pending = mstatus_mie_q & mie_mtie_q & mtip;
    // Reset masks the trap so nothing is reported or committed while rst_i is high.
    assign trap        = ~rst_i & retire_i &
                         (irq_pending | inst_invalid_i | csr_illegal | exc_request_i);
    assign trap_cause  = irq_pending                    ? CAUSE_MTIMER  :
                         (inst_invalid_i | csr_illegal) ? CAUSE_ILLEGAL :
                                                          exc_cause_i;
    assign csr_nop     = ((op == CSR_SET) || (op == CSR_CLEAR)) && (csr_wdata_i == '0);
    assign csr_we      = retire_i & ~trap & csr_active & csr_impl & ~csr_ro & ~csr_nop;
    assign csr_new     = csr_apply(op, csr_rdata_o, csr_wdata_i);

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q;
        if (retire_i && !trap) begin
            minstret_d = minstret_q + 64'd1;
        end
        if (trap) begin
            mepc_d         = pc_i & ~32'h3;
            mcause_d       = trap_cause;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else begin
            // Counter writes override the increments chosen above.
            if (csr_we) begin
                case (csr_addr_i)
                    CSR_MSTATUS: begin
                        mstatus_mie_d  = csr_new[MSTATUS_MIE_BIT];
                        mstatus_mpie_d = csr_new[MSTATUS_MPIE_BIT];
                    end
                    CSR_MIE:       mie_mtie_d = csr_new[MIE_MTIE_BIT];
                    CSR_MTVEC:     mtvec_d    = csr_new;
                    CSR_MSCRATCH:  mscratch_d = csr_new;
                    CSR_MEPC:      mepc_d     = csr_new & ~32'h3;
                    CSR_MCAUSE:    mcause_d   = csr_new;
                    CSR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], csr_new};
                    CSR_MCYCLEH:   mcycle_d   = {csr_new, mcycle_q[31:0]};
                    CSR_MINSTRET:  minstret_d = {minstret_q[63:32], csr_new};
                    CSR_MINSTRETH: minstret_d = {csr_new, minstret_q[31:0]};
                    default: ;
                endcase
            end
            if (retire_i && exc_ret_i) begin
                mstatus_mie_d  = mstatus_mpie_q;
                mstatus_mpie_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mtvec_q        <= RESET_MTVEC;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

    assign exception_present_o = trap;
    assign trap_vector_o       = {mtvec_q[31:2], 2'b00};
    assign mepc_out_o          = mepc_q;

endmodule
